// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
// Optional early-out multiply is enabled with `define MDU_EARLY_OUT_EN (see mdu_iter).
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} mduState;

  // Divide-by-zero LO value; sliced down to WIDTH (WIDTH <= 64).
  localparam logic [63:0] DIV_ZERO_LO = '1;

endpackage

// File: rtl/mdu_sign_fix.sv
// Sign handling for the MDU: operand magnitudes on entry and result negation in FIXUP,
// both built from one W-bit two's-complement negator.
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             isSigned,
  output logic [WIDTH-1:0] absA,
  output logic [WIDTH-1:0] absB,
  input  logic             isMul,
  input  logic             negHi,
  input  logic             negLo,
  input  logic [WIDTH-1:0] resHi,
  input  logic [WIDTH-1:0] resLo,
  output logic [WIDTH-1:0] fixHi,
  output logic [WIDTH-1:0] fixLo
);

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  always_comb begin
    absA = (isSigned && opA[WIDTH-1]) ? neg(opA) : opA;
    absB = (isSigned && opB[WIDTH-1]) ? neg(opB) : opB;
    fixHi = resHi;
    fixLo = resLo;
    if (isMul) begin
      // 2W negate: low half negates alone, high half takes the carry only when low is zero.
      if (negLo) begin
        fixLo = neg(resLo);
        fixHi = ~resHi + {{(WIDTH-1){1'b0}}, (resLo == '0)};
      end
    end else begin
      if (negHi) fixHi = neg(resHi);
      if (negLo) fixLo = neg(resLo);
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit with HI/LO, MTHI/MTLO and flush.
// `define MDU_EARLY_OUT_EN lets multiply leave CALC once the remaining multiplier bits are zero.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  input  logic             hiWe,
  input  logic             loWe,
  input  logic [WIDTH-1:0] wrData,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mduState state, stateNxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;
  logic               isDiv, qSign, rSign, dzQ, lastStep, isSignedOp;
  logic [WIDTH-1:0]   absA, absB, resHi, resLo, fixHi, fixLo;
  logic [WIDTH:0]     divShift, divDiff;

  assign isSignedOp = (op == MDU_MULT) || (op == MDU_DIV);

  mdu_sign_fix #(.WIDTH(WIDTH)) uSignFix (
    .opA(opA), .opB(opB), .isSigned(isSignedOp), .absA(absA), .absB(absB),
    .isMul(!isDiv), .negHi(rSign), .negLo(qSign & ~dzQ),
    .resHi(resHi), .resLo(resLo), .fixHi(fixHi), .fixLo(fixLo)
  );

  // Divide: acc[W-1:0] is the partial remainder, mplier shifts dividend out and quotient in.
  // mcand holds the divisor low and the dividend magnitude high (returned as HI on /0).
  always_comb begin
    divShift = {acc[WIDTH-1:0], mplier[WIDTH-1]};
    divDiff  = divShift - {1'b0, mcand[WIDTH-1:0]};
    if (isDiv) begin
      resHi = dzQ ? mcand[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
      resLo = mplier;
    end else begin
      resHi = acc[2*WIDTH-1:WIDTH];
      resLo = acc[WIDTH-1:0];
    end
  end

`ifdef MDU_EARLY_OUT_EN
  assign lastStep = (cnt == CNT_W'(WIDTH-1)) || (!isDiv && mplier[WIDTH-1:1] == '0);
`else
  assign lastStep = (cnt == CNT_W'(WIDTH-1));
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (start) stateNxt = CALC;
      CALC:    if (lastStep) stateNxt = FIXUP;
      FIXUP:   stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
    if (flush) stateNxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      divZero <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      isDiv   <= 1'b0;
      qSign   <= 1'b0;
      rSign   <= 1'b0;
      dzQ     <= 1'b0;
    end else begin
      done    <= 1'b0;
      divZero <= 1'b0;
      busy    <= (stateNxt != IDLE);
      case (state)
        IDLE: begin
          if (hiWe) hi <= wrData;
          if (loWe) lo <= wrData;
          if (start && !flush) begin
            cnt    <= '0;
            acc    <= '0;
            isDiv  <= op[1];
            qSign  <= isSignedOp & (opA[WIDTH-1] ^ opB[WIDTH-1]);
            rSign  <= isSignedOp & opA[WIDTH-1];
            dzQ    <= op[1] && (opB == '0);
            mcand  <= op[1] ? {absA, absB} : {{WIDTH{1'b0}}, absA};
            mplier <= op[1] ? absA : absB;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (isDiv) begin
            acc    <= {{WIDTH{1'b0}}, divDiff[WIDTH] ? divShift[WIDTH-1:0] : divDiff[WIDTH-1:0]};
            mplier <= {mplier[WIDTH-2:0], ~divDiff[WIDTH]};
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
        end
        FIXUP: begin
          if (!flush) begin
            hi      <= fixHi;
            lo      <= dzQ ? DIV_ZERO_LO[WIDTH-1:0] : fixLo;
            done    <= 1'b1;
            divZero <= dzQ;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed scoreboard bench for mdu_iter: latency, signs, /0, flush, reset and MTHI/MTLO.
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush, hiWe, loWe;
  logic [1:0]  op;
  logic [31:0] opA, opB, wrData;
  logic        busy, done, divZero;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } sbEntry;

  sbEntry      sb[$];
  int          nChecks = 0, nPass = 0, nFail = 0, cyc = 0;
  logic [31:0] expHi, expLo;
  logic        sawDone;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB),
    .flush(flush), .hiWe(hiWe), .loWe(loWe), .wrData(wrData),
    .busy(busy), .done(done), .divZero(divZero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nChecks++;
    assert (obs === expv) nPass++;
    else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic sbEntry model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    sbEntry e;
    logic signed [63:0] sx, sy, q, r;
    logic [63:0] p;
    sx = {{32{a[31]}}, a};
    sy = {{32{b[31]}}, b};
    e.dz  = 1'b0;
    e.lat = 34;
    case (o)
      MDU_MULT:  begin p = sx * sy; e.hi = p[63:32]; e.lo = p[31:0]; end
      MDU_MULTU: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      MDU_DIV: begin
        if (b == 32'b0) begin e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; end
        else begin q = sx / sy; r = sx % sy; e.hi = r[31:0]; e.lo = q[31:0]; end
      end
      default: begin
        if (b == 32'b0) begin e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; end
        else begin e.hi = a % b; e.lo = a / b; end
      end
    endcase
`ifdef MDU_EARLY_OUT_EN
    if (!o[1]) begin
      logic [31:0] mb;
      int steps;
      mb = (o == MDU_MULT && b[31]) ? -b : b;
      steps = 1;
      for (int i = 1; i < 32; i++) if (mb[i]) steps = i + 1;
      e.lat = steps + 2;
    end
`endif
    return e;
  endfunction

  // Drive start for one cycle; returns in cycle 1 of the operation.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic hw, input logic lw, input logic [31:0] wd);
    sb.push_back(model(o, a, b));
    op = o; opA = a; opB = b; start = 1'b1;
    hiWe = hw; loWe = lw; wrData = wd;
    cyc = 0;
    tick();
    start = 1'b0; hiWe = 1'b0; loWe = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    sbEntry e;
    bit got, busyOk;
    got = 0;
    busyOk = 1;
    while (!got && cyc < 200) begin
      if (done === 1'b1) got = 1;
      else begin
        if (busy !== 1'b1) busyOk = 0;
        tick();
      end
    end
    e = sb.pop_front();
    chk({tag, " done seen"}, 64'(got), 64'd1);
    chk({tag, " latency"}, 64'(cyc), 64'(e.lat));
    chk({tag, " busy during op"}, 64'(busyOk), 64'd1);
    chk({tag, " busy at done"}, 64'(busy), 64'd0);
    chk({tag, " hi"}, 64'(hi), 64'(e.hi));
    chk({tag, " lo"}, 64'(lo), 64'(e.lo));
    chk({tag, " divZero"}, 64'(divZero), 64'(e.dz));
    tick();
    chk({tag, " done one cycle"}, 64'(done), 64'd0);
    expHi = e.hi;
    expLo = e.lo;
  endtask

  task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    issue(o, a, b, 1'b0, 1'b0, 32'b0);
    waitDone(tag);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; flush = 1'b0; hiWe = 1'b0; loWe = 1'b0;
    op = 2'b00; opA = '0; opB = '0; wrData = '0;
    tick(); tick();
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset divZero", 64'(divZero), 64'd0);
    rst = 1'b1;
    tick();

    loWe = 1'b1; wrData = 32'h1;
    tick();
    loWe = 1'b0;
    chk("mtlo idle", 64'(lo), 64'd1);
    chk("mtlo leaves hi", 64'(hi), 64'd0);

    runOp(MDU_MULT, -32'sd3, 32'd5, "mult -3*5");
    chk("mult -3*5 hi const", 64'(expHi), 64'hFFFF_FFFF);
    chk("mult -3*5 lo const", 64'(lo), 64'hFFFF_FFF1);
    runOp(MDU_DIVU, 32'd100, 32'd7, "divu 100/7");
    chk("divu 100/7 lo const", 64'(lo), 64'h0000_000E);
    chk("divu 100/7 hi const", 64'(hi), 64'h0000_0002);
    runOp(MDU_DIV, -32'sd7, 32'd2, "div -7/2");
    chk("div -7/2 lo const", 64'(lo), 64'hFFFF_FFFD);
    chk("div -7/2 hi const", 64'(hi), 64'hFFFF_FFFF);
    runOp(MDU_DIVU, 32'd1234, 32'd0, "divu 1234/0");
    chk("divu /0 hi const", 64'(hi), 64'h0000_04D2);
    runOp(MDU_DIV, 32'hFFFF_FF85, 32'd0, "div neg/0");
    runOp(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div minneg/-1");
    chk("div minneg/-1 lo const", 64'(lo), 64'h8000_0000);
    runOp(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max*max");
    runOp(MDU_MULT, 32'h8000_0000, 32'h8000_0000, "mult minneg^2");
    runOp(MDU_MULTU, 32'd7, 32'd6, "multu 7*6");
    chk("multu 7*6 lo const", 64'(lo), 64'h0000_002A);
    runOp(MDU_DIV, 32'd100, -32'sd7, "div 100/-7");
    for (int i = 0; i < 6; i++)
      runOp(2'($urandom_range(0, 3)), $urandom, $urandom >> $urandom_range(0, 28), "random op");

    // MTHI while busy is dropped
    issue(MDU_DIVU, 32'd50, 32'd5, 1'b0, 1'b0, 32'b0);
    hiWe = 1'b1; wrData = 32'hA5A5_A5A5;
    tick();
    hiWe = 1'b0;
    chk("mthi while busy ignored", 64'(hi), 64'(expHi));
    waitDone("divu 50/5");

    // MTHI/MTLO together with start: write lands, result overwrites later
    issue(MDU_DIVU, 32'd100, 32'd7, 1'b1, 1'b1, 32'h1234_5678);
    chk("write with start hi", 64'(hi), 64'h1234_5678);
    chk("write with start lo", 64'(lo), 64'h1234_5678);
    waitDone("divu after write");

    // Flush in cycle 10 of a multiply
    issue(MDU_MULTU, 32'd9, 32'd9, 1'b0, 1'b0, 32'b0);
    sawDone = 1'b0;
    while (cyc < 10) begin
      if (done === 1'b1) sawDone = 1'b1;
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    void'(sb.pop_back());
    chk("flush no done", 64'(sawDone | done), 64'd0);
    chk("flush busy low", 64'(busy), 64'd0);
    chk("flush keeps hi", 64'(hi), 64'(expHi));
    chk("flush keeps lo", 64'(lo), 64'(expLo));
    runOp(MDU_MULTU, 32'd9, 32'd9, "multu 9*9 after flush");
    chk("multu 9*9 lo const", 64'(lo), 64'h0000_0051);

    // flush and start together: start dropped
    op = MDU_MULTU; opA = 32'd3; opB = 32'd3; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush beats start busy", 64'(busy), 64'd0);
    tick(); tick();
    chk("flush beats start no done", 64'(done), 64'd0);
    chk("flush beats start lo kept", 64'(lo), 64'(expLo));

    // Reset in cycle 5 of a divide
    issue(MDU_DIV, -32'sd100, 32'd3, 1'b0, 1'b0, 32'b0);
    while (cyc < 5) tick();
    rst = 1'b0;
    tick();
    void'(sb.pop_back());
    chk("mid reset hi", 64'(hi), 64'd0);
    chk("mid reset lo", 64'(lo), 64'd0);
    chk("mid reset busy", 64'(busy), 64'd0);
    chk("mid reset done", 64'(done), 64'd0);
    chk("mid reset divZero", 64'(divZero), 64'd0);
    rst = 1'b1;
    tick();
    runOp(MDU_DIV, -32'sd100, 32'd3, "div after reset");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
